// File: rtl/sata_xcvr_rst_seq_pkg.sv
// Shared types and helpers for the SATA transceiver reset sequencer.
// State encoding is visible on the sequencer's state port.
package sata_xcvr_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET   = 3'd0,
    ST_WAIT_TX = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_READY   = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sata_xcvr_lock_filter.sv
// RX lock stability filter: flags stable once the qualified input has been
// high for LOCK_STABLE consecutive enabled cycles.
module sata_xcvr_lock_filter
  import sata_xcvr_rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic qual,
  output logic stable
);

  localparam int CNT_W = cnt_w(LOCK_STABLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!(en && qual)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sata_xcvr_rst_seq.sv
// Reset sequencer in front of the SATA transceiver reset controller.
// Define SATA_XCVR_RST_SEQ_STAT_EN to add the lol_count loss-of-link counter.
module sata_xcvr_rst_seq
  import sata_xcvr_rst_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LOCK_STABLE    = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               restart,
  input  logic               tx_ready,
  input  logic               rx_ready,
  input  logic               rx_is_lockedtodata,
  output logic               xcvr_reset,
  output logic               link_ready,
  output logic               fault,
  output logic [STATE_W-1:0] state
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
  ,
  output logic [15:0]        lol_count
`endif
);

  localparam int RST_W = cnt_w(RST_CYCLES);
  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             xcvr_reset_q, xcvr_reset_d;
  logic             link_ready_q, link_ready_d;
  logic             fault_q, fault_d;
  logic             qual_s, stable_s, timeout_s, retry_s, exhausted_s;

  assign qual_s      = rx_ready && rx_is_lockedtodata;
  assign timeout_s   = (to_cnt_q == TO_LAST);
  assign exhausted_s = (retry_q == RTY_MAX);

  sata_xcvr_lock_filter #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_filter (
    .clock (clock),
    .reset (reset),
    .en    (state_q == ST_WAIT_RX),
    .qual  (qual_s),
    .stable(stable_s)
  );

  // Progress beats timeout; restart overrides every other decision.
  always_comb begin
    state_d = state_q;
    retry_s = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_TX;
        else                       state_d = ST_RESET;
      end
      ST_WAIT_TX: begin
        if (tx_ready)       state_d = ST_WAIT_RX;
        else if (timeout_s) retry_s = 1'b1;
        else                state_d = ST_WAIT_TX;
      end
      ST_WAIT_RX: begin
        if (!tx_ready)      state_d = ST_RESET;
        else if (stable_s)  state_d = ST_READY;
        else if (timeout_s) retry_s = 1'b1;
        else                state_d = ST_WAIT_RX;
      end
      ST_READY: begin
        if (!(tx_ready && qual_s)) state_d = ST_RESET;
        else                       state_d = ST_READY;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET;
    endcase

    if (retry_s) begin
      if (exhausted_s) state_d = ST_FAULT;
      else             state_d = ST_RESET;
    end else begin
      state_d = state_d;
    end
    if (restart) begin
      state_d = ST_RESET;
    end else begin
      state_d = state_d;
    end

    if (restart || state_d == ST_READY) begin
      retry_d = '0;
    end else if (retry_s && !exhausted_s) begin
      retry_d = retry_q + RTY_W'(1);
    end else begin
      retry_d = retry_q;
    end

    // A restart re-enters RESET, so it re-arms the hold and timeout counters.
    if (restart || state_d != state_q) begin
      rst_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      if (state_q == ST_RESET) rst_cnt_d = rst_cnt_q + RST_W'(1);
      else                     rst_cnt_d = rst_cnt_q;
      if ((state_q == ST_WAIT_TX || state_q == ST_WAIT_RX) && to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_d = to_cnt_q;
      end
    end

    xcvr_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
    link_ready_d = (state_d == ST_READY);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      xcvr_reset_q <= 1'b1;
      link_ready_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      xcvr_reset_q <= xcvr_reset_d;
      link_ready_q <= link_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign xcvr_reset = xcvr_reset_q;
  assign link_ready = link_ready_q;
  assign fault      = fault_q;
  assign state      = state_q;

`ifdef SATA_XCVR_RST_SEQ_STAT_EN
  logic [15:0] lol_count_q, lol_count_d;
  logic        loss_s;

  assign loss_s = (state_q == ST_READY) && !(tx_ready && qual_s) && !restart;

  always_comb begin
    if (loss_s && lol_count_q != 16'hFFFF) lol_count_d = lol_count_q + 16'd1;
    else                                   lol_count_d = lol_count_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lol_count_q <= 16'd0;
    end else begin
      lol_count_q <= lol_count_d;
    end
  end

  assign lol_count = lol_count_q;
`endif

endmodule

// File: tb/tb_sata_xcvr_rst_seq.sv
// Self-checking bench for sata_xcvr_rst_seq: directed bring-up scenarios with
// timing constants, then randomized inputs against a cycle-level reference model.
module tb_sata_xcvr_rst_seq;

  localparam int P_RST  = 4;
  localparam int P_TO   = 100;
  localparam int P_LS   = 8;
  localparam int P_MAXR = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       restart = 1'b0;
  logic       tx_ready = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_is_lockedtodata = 1'b0;
  logic       xcvr_reset, link_ready, fault;
  logic [2:0] state;
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
  logic [15:0] lol_count;
`endif

  sata_xcvr_rst_seq #(
    .RST_CYCLES(P_RST), .TIMEOUT_CYCLES(P_TO), .LOCK_STABLE(P_LS), .MAX_RETRIES(P_MAXR)
  ) dut (
    .clock(clock), .reset(reset), .restart(restart), .tx_ready(tx_ready),
    .rx_ready(rx_ready), .rx_is_lockedtodata(rx_is_lockedtodata),
    .xcvr_reset(xcvr_reset), .link_ready(link_ready), .fault(fault), .state(state)
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
    , .lol_count(lol_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int first_link = -1;
  int first_fault = -1;
  int last_xhi = -1;

  // Reference model: phase number, cycles in phase, qualified run, retries, losses.
  int m_state, m_age, m_run, m_retries, m_lol;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_age = 0; m_run = 0; m_retries = 0; m_lol = 0;
  endtask

  task automatic m_step();
    int nxt;
    bit charge, loss, q;
    nxt = m_state; charge = 1'b0; loss = 1'b0;
    q = rx_ready && rx_is_lockedtodata;
    case (m_state)
      0: if (m_age + 1 >= P_RST) nxt = 1;
      1: begin
        if (tx_ready) nxt = 2;
        else if (m_age + 1 >= P_TO) charge = 1'b1;
      end
      2: begin
        if (!tx_ready) nxt = 0;
        else if (m_run >= P_LS) nxt = 3;
        else if (m_age + 1 >= P_TO) charge = 1'b1;
      end
      3: if (!(tx_ready && q)) begin nxt = 0; loss = 1'b1; end
      default: ;
    endcase
    if (charge) begin
      if (m_retries >= P_MAXR) nxt = 4;
      else begin nxt = 0; m_retries++; end
    end
    if (nxt == 3) m_retries = 0;
    if (restart) begin nxt = 0; m_retries = 0; loss = 1'b0; end
    if (loss && m_lol < 65535) m_lol++;
    m_run = (m_state == 2 && nxt == 2 && q) ? m_run + 1 : 0;
    m_age = (nxt != m_state || restart) ? 0 : m_age + 1;
    m_state = nxt;
  endtask

  task automatic tick();
    int exp_outs;
    @(posedge clock);
    if (!reset) m_reset();
    else m_step();
    #1;
    cyc++;
    exp_outs = {29'd0, (m_state == 0 || m_state == 4), (m_state == 3), (m_state == 4)};
    chk_eq("state", int'(state), m_state);
    chk_eq("outs", int'({xcvr_reset, link_ready, fault}), exp_outs);
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
    chk_eq("lol_count", int'(lol_count), m_lol);
`endif
    if (link_ready && first_link < 0) first_link = cyc;
    if (fault && first_fault < 0) first_fault = cyc;
    if (xcvr_reset) last_xhi = cyc;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clr_marks();
    first_link = -1; first_fault = -1; last_xhi = -1;
  endtask

  // Cycle 0 is the cycle after the last edge that samples reset low.
  task automatic do_reset();
    reset = 1'b0; restart = 1'b0;
    tx_ready = 1'b0; rx_ready = 1'b0; rx_is_lockedtodata = 1'b0;
    tick(); tick();
    reset = 1'b1;
    cyc = 0;
    clr_marks();
  endtask

  initial begin
    int mode;
    int c;

    // Reset values and nominal bring-up.
    do_reset();
    chk_eq("rst_state", int'(state), 0);
    chk_eq("rst_xcvr", int'(xcvr_reset), 1);
    chk_eq("rst_link", int'(link_ready), 0);
    chk_eq("rst_fault", int'(fault), 0);
    run_to(10);
    chk_eq("nom_xhi_end", last_xhi, 3);
    tx_ready = 1'b1;
    run_to(20);
    rx_ready = 1'b1; rx_is_lockedtodata = 1'b1;
    run_to(32);
    chk_eq("nom_rise", first_link, 29);
    chk_eq("nom_state", int'(state), 3);

    // Lock glitch at qualified count 5, then loss in READY.
    do_reset();
    run_to(10); tx_ready = 1'b1;
    run_to(20); rx_ready = 1'b1; rx_is_lockedtodata = 1'b1;
    run_to(25); rx_is_lockedtodata = 1'b0;
    run_to(26); rx_is_lockedtodata = 1'b1;
    run_to(40);
    chk_eq("glitch_rise", first_link, 35);
    rx_ready = 1'b0;
    run_to(41);
    rx_ready = 1'b1;
    chk_eq("loss_state", int'(state), 0);
    chk_eq("loss_link", int'(link_ready), 0);
    clr_marks();
    run_to(50);
    chk_eq("loss_xhi_end", last_xhi, 44);
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
    chk_eq("loss_lol", int'(lol_count), 1);
`endif

    // Timeouts to FAULT, then restart with a cleared retry budget.
    do_reset();
    run_to(320);
    chk_eq("fault_cyc", first_fault, 312);
    chk_eq("fault_state", int'(state), 4);
    chk_eq("fault_xcvr", int'(xcvr_reset), 1);
    c = cyc;
    restart = 1'b1; tick(); restart = 1'b0;
    chk_eq("restart_state", int'(state), 0);
    chk_eq("restart_fault", int'(fault), 0);
    clr_marks();
    run_to(c + 330);
    chk_eq("refault_cyc", first_fault, c + 313);

    // Restart coinciding with a WAIT_RX timeout after two charged retries.
    do_reset();
    run_to(220); tx_ready = 1'b1;
    run_to(320);
    restart = 1'b1; tick(); restart = 1'b0;
    chk_eq("sim_to_state", int'(state), 0);
    run_to(426);
    chk_eq("sim_to_retry", int'(state), 0);

    // Restart coinciding with a READY loss.
    do_reset();
    run_to(10); tx_ready = 1'b1;
    run_to(20); rx_ready = 1'b1; rx_is_lockedtodata = 1'b1;
    run_to(31);
    rx_ready = 1'b0; restart = 1'b1; tick(); restart = 1'b0; rx_ready = 1'b1;
    chk_eq("sim_loss_state", int'(state), 0);
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
    chk_eq("sim_loss_lol", int'(lol_count), 0);
`endif
    run_to(60);
    chk_eq("sim_loss_ready", int'(state), 3);
    rx_is_lockedtodata = 1'b0; tick(); rx_is_lockedtodata = 1'b1;
`ifdef SATA_XCVR_RST_SEQ_STAT_EN
    chk_eq("sim_loss_lol2", int'(lol_count), 1);
`endif

    // Randomized segments against the reference model.
    do_reset();
    mode = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i % 400 == 0) mode = $urandom_range(0, 3);
      tx_ready = (mode == 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      rx_ready = ($urandom_range(0, 99) != 0);
      rx_is_lockedtodata = (mode == 3) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 49) != 0);
      restart = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 1999) != 0);
      tick();
    end
    reset = 1'b1; restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
